// File: rtl/arb_pkg.sv
// Shared constants and state type for the eight-requester arbiter.
`timescale 1ns/1ps
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational winner pick: rotate req so that bit last_id-1 sits on top,
// take the highest set bit, then rotate the index back.
`timescale 1ns/1ps
module rr_priority_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  input  logic             rr_mode,
  output logic [ID_W-1:0]  winner,
  output logic             any
);

  logic [ID_W-1:0]    base;
  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [ID_W-1:0]    pos;

  // Fixed priority is simply a rotation of zero.
  assign base    = rr_mode ? last_id : '0;
  assign doubled = {req, req} >> base;
  assign rotated = doubled[N_REQ-1:0];
  assign any     = |req;

  always_comb begin
    pos = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (rotated[j]) pos = ID_W'(j);
    end
  end

  assign winner = pos + base;

endmodule

// File: rtl/req_arbiter_8.sv
// Eight-client arbiter: fixed or round-robin pick in IDLE, grant held while
// the owner keeps requesting, optionally revoked after MAX_HOLD cycles.
`timescale 1ns/1ps
module req_arbiter_8
  import arb_pkg::*;
#(
  parameter int  MAX_HOLD = 16,
  localparam int HOLD_W   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             rr_mode,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic             timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  state_t            state, state_next;
  logic [HOLD_W-1:0] hold, hold_next;
  logic [ID_W-1:0]   last_id, last_id_next;
  logic [ID_W-1:0]   grant_id_next;
  logic [N_REQ-1:0]  grant_next;
  logic              timeout_next;
  logic [ID_W-1:0]   pick_id;
  logic              pick_any;
  logic              owner_req;
  logic              at_limit;

  rr_priority_pick u_pick (
    .req     (req),
    .last_id (last_id),
    .rr_mode (rr_mode),
    .winner  (pick_id),
    .any     (pick_any)
  );

  assign owner_req = req[grant_id];
  assign at_limit  = (MAX_HOLD != 0) && (hold == HOLD_LIMIT);
  assign busy      = (state == ST_GRANT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold     <= '0;
      last_id  <= '0;
      grant    <= '0;
      grant_id <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      hold     <= hold_next;
      last_id  <= last_id_next;
      grant    <= grant_next;
      grant_id <= grant_id_next;
      timeout  <= timeout_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (pick_any) state_next = ST_GRANT;
      ST_GRANT: if (!owner_req || at_limit) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Every release or revoke drops grant for one cycle before any new owner.
  always_comb begin
    hold_next     = hold;
    last_id_next  = last_id;
    grant_id_next = grant_id;
    grant_next    = '0;
    timeout_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          hold_next     = HOLD_W'(1);
          last_id_next  = pick_id;
          grant_id_next = pick_id;
          grant_next    = N_REQ'(1) << pick_id;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          hold_next = '0;
        end else if (at_limit) begin
          hold_next    = '0;
          timeout_next = 1'b1;
        end else begin
          grant_next = grant;
          if (hold != '1) hold_next = hold + 1'b1;
        end
      end
      default: begin
        hold_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_req_arbiter_8.sv
// Scoreboard bench for req_arbiter_8: a queue-driven reference model feeds a
// decoupled monitor, plus per-cycle invariants on the grant outputs.
`timescale 1ns/1ps
module tb_req_arbiter_8;

  localparam int MH = 4;

  typedef struct {
    logic [7:0] grant;
    logic [2:0] id;
    logic       busy;
    logic       timeout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       rr_mode;
  logic [7:0] grant, grant_u;
  logic [2:0] grant_id, grant_id_u;
  logic       busy, busy_u, timeout, timeout_u;

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];

  bit   m_owned;
  int   m_owner, m_hold, m_last;

  always #5 clk = ~clk;

  req_arbiter_8 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .rr_mode(rr_mode),
    .grant(grant), .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  req_arbiter_8 #(.MAX_HOLD(0)) dut_u (
    .clk(clk), .rst(rst), .req(req), .rr_mode(rr_mode),
    .grant(grant_u), .grant_id(grant_id_u), .busy(busy_u), .timeout(timeout_u)
  );

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
    tests++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  // Search down from last-1 with wraparound; fixed mode searches from 7.
  function automatic int modelPick(input logic [7:0] r, input logic m, input int last);
    int base;
    base = m ? last : 0;
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (base - k + 8) % 8;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic modelStep(input logic [7:0] r, input logic m, output exp_t e);
    e.timeout = 1'b0;
    if (!m_owned) begin
      if (r != 8'h00) begin
        m_owner = modelPick(r, m, m_last);
        m_owned = 1'b1;
        m_hold  = 1;
        m_last  = m_owner;
      end
    end else if (!r[m_owner]) begin
      m_owned = 1'b0;
    end else if (m_hold == MH) begin
      m_owned   = 1'b0;
      e.timeout = 1'b1;
    end else begin
      m_hold++;
    end
    e.busy  = m_owned;
    e.grant = m_owned ? (8'd1 << m_owner) : 8'd0;
    e.id    = 3'(m_owner);
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic m);
    exp_t e;
    req     = r;
    rr_mode = m;
    modelStep(r, m, e);
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst = 1'b1;
    req = 8'hFF;
    #1;
    checkOutput("rst_grant", grant, 8'h00);
    checkOutput("rst_busy", 8'(busy), 8'h00);
    checkOutput("rst_grant_id", 8'(grant_id), 8'h00);
    checkOutput("rst_timeout", 8'(timeout), 8'h00);
    sb_q.delete();
    m_owned = 1'b0;
    m_owner = 0;
    m_hold  = 0;
    m_last  = 0;
    @(posedge clk);
    #2;
    checkOutput("rst_hold_grant", grant, 8'h00);
    rst = 1'b0;
    req = 8'h00;
  endtask

  // Scoreboard monitor: one expected entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("sb_grant", grant, e.grant);
        checkOutput("sb_busy", 8'(busy), 8'(e.busy));
        checkOutput("sb_timeout", 8'(timeout), 8'(e.timeout));
        if (e.busy) checkOutput("sb_grant_id", 8'(grant_id), 8'(e.id));
      end
    end
  end

  initial begin
    logic prev_to;
    prev_to = 1'b0;
    forever begin
      @(negedge clk);
      checkOutput("inv_onehot", 8'($onehot0(grant)), 8'h01);
      checkOutput("inv_busy", 8'(busy), 8'(grant != 8'h00));
      if (busy) checkOutput("inv_grant_id", grant, 8'd1 << grant_id);
      if (prev_to) checkOutput("inv_to_pulse", 8'(timeout), 8'h00);
      prev_to = timeout;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] r;
    logic       m;
    int         e_id;

    rst = 1'b1; req = 8'h00; rr_mode = 1'b0;
    m_owned = 1'b0; m_owner = 0; m_hold = 0; m_last = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Fixed priority: 5 wins over 2, then 2 after a bubble.
    applyStimulus(8'b0010_0100, 1'b0);
    checkOutput("fix_first_grant", grant, 8'b0010_0000);
    checkOutput("fix_first_id", 8'(grant_id), 8'd5);
    applyStimulus(8'b0010_0100, 1'b0);
    applyStimulus(8'b0000_0100, 1'b0);
    checkOutput("fix_bubble", grant, 8'h00);
    applyStimulus(8'b0000_0100, 1'b0);
    checkOutput("fix_second_grant", grant, 8'b0000_0100);
    checkOutput("fix_second_id", 8'(grant_id), 8'd2);

    // Mid-grant reset with all requests high.
    doReset();

    // Round-robin rotation 7,6,...,0,7 with owners dropping after one cycle.
    for (int k = 0; k < 9; k++) begin
      e_id = (15 - k) % 8;
      applyStimulus(8'hFF, 1'b1);
      checkOutput("rr_id", 8'(grant_id), 8'(e_id));
      r = 8'hFF & ~(8'd1 << e_id);
      applyStimulus(r, 1'b1);
      checkOutput("rr_bubble", grant, 8'h00);
    end

    // Hold limit: fixed regrants 7, round-robin moves on to 0.
    for (int pass = 0; pass < 2; pass++) begin
      doReset();
      for (int i = 0; i < 6; i++) begin
        applyStimulus(8'b1000_0001, 1'(pass));
        if (i == 0) checkOutput("hold_first_id", 8'(grant_id), 8'd7);
        if (i == 3) checkOutput("hold_last_cycle", grant, 8'h80);
        if (i == 4) begin
          checkOutput("hold_timeout", 8'(timeout), 8'h01);
          checkOutput("hold_revoked", grant, 8'h00);
        end
        if (i == 5) checkOutput("hold_regrant_id", 8'(grant_id), (pass == 0) ? 8'd7 : 8'd0);
      end
    end

    // Unlimited hold on the MAX_HOLD=0 instance.
    doReset();
    for (int i = 0; i < 101; i++) begin
      applyStimulus(8'b0000_1000, 1'b0);
      checkOutput("unl_grant", grant_u, 8'b0000_1000);
      checkOutput("unl_timeout", 8'(timeout_u), 8'h00);
    end

    // Random traffic, with sticky requests so grants can run to the limit.
    r = 8'h00;
    m = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) doReset();
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      if ($urandom_range(0, 15) == 0) r = 8'h00;
      if ($urandom_range(0, 7) == 0) m = ~m;
      applyStimulus(r, m);
    end

    checkOutput("sb_drain", 8'(sb_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
